branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Write-side partner of the branch history table (BHT). Fetch pushes each predicted branch (BHT index, predicted direction, fall-through PC) into an in-order pending queue. Execute resolves branches oldest-first. The block compares the actual outcome against the prediction and drives the BHT update port. On a mismatch it raises mispredict/redirect and flushes the younger queued entries.

Parameters:
LOWER, 5, BHT index width; must match the BHT's index width
DEPTH, 4, pending-branch queue entries; power of 2, at least 2
PC_W, 32, program counter width

Ports:
clk  in  1  clock, rising edge
arst  in  1  asynchronous reset, active-high
push_valid  in  1  fetch offers a predicted branch
push_ready  out  1  queue accepts push; = !full && state==RUN
push_idx  in  LOWER  BHT index of the branch PC
push_pred  in  1  predicted direction (1 = taken)
push_fallthru  in  PC_W  PC+4 of the branch
res_valid  in  1  execute resolves the oldest pending branch
res_taken  in  1  conditional branch actually taken
res_jump  in  1  unconditional jump
res_target  in  PC_W  computed target address
upd_en  out  1  BHT write enable, 1-cycle pulse
upd_addr  out  LOWER  BHT write address
upd_taken  out  1  BHT was_taken input
upd_jumped  out  1  BHT jumped input
mispredict  out  1  1-cycle pulse
redirect_pc  out  PC_W  correct next PC; valid while mispredict=1
underflow  out  1  sticky error: resolve arrived while queue empty

Behaviour:
- Reset (arst=1, asynchronous): queue empty, pointers and count 0, state RUN. upd_en, upd_addr, upd_taken, upd_jumped, mispredict, redirect_pc and underflow are all 0.
- Queue: circular buffer of entries {idx, pred, fallthru}.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
  - full = (count==DEPTH); empty = (count==0).
- Push: occurs on a rising edge when push_valid && push_ready.
  - push_ready is combinational.
  - When full, push_ready stays 0 even if a pop happens in the same cycle (no full bypass).
- Resolve: occurs when res_valid && !empty && state==RUN. The head entry pops, and the following outputs are registered, appearing 1 cycle after the resolve edge:
  - upd_en=1, upd_addr=head.idx, upd_taken=res_taken, upd_jumped=res_jump;
  - actual = res_taken | res_jump;
  - mispredict = (actual != head.pred);
  - redirect_pc = actual ? res_target : head.fallthru.
- No resolve in a cycle: upd_en=0 and mispredict=0. The remaining update and redirect outputs hold their last values.
- Push and resolve in the same cycle (not full, not empty): both take effect; count is unchanged.
- res_valid while empty: ignored, no update, and underflow sets. underflow clears only on reset.
- Push and resolve to an empty queue in the same cycle: the resolve is ignored (no bypass) and underflow sets; the push is accepted.
- State machine (RUN, FLUSH):
  - RUN -> FLUSH on a resolve that mispredicts. On that same edge all remaining entries are discarded: pointers 0, count 0. Any push offered in that cycle is dropped, even if push_ready was 1.
  - FLUSH -> RUN unconditionally after 1 cycle.
  - In FLUSH: push_ready=0 and res_valid is ignored, with no underflow.
- Correct prediction: state stays RUN and the queue is retained.

Optional Feature:
BRU_STATS_EN defined:
- Adds output ports stat_branches[15:0] and stat_mispredicts[15:0].
- Both are saturating at 16'hFFFF, increment on each accepted resolve and each mispredicting resolve respectively, and reset to 0.

BRU_STATS_EN undefined:
- These ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package bru_pkg holds:
  - the pending-entry struct/field widths {idx, pred, fallthru};
  - the state encodings RUN=1'b0, FLUSH=1'b1;
  - the stats counter width 16.
- One sub-module, bru_fifo: parameterised circular queue with push, pop and synchronous clear, exposing full, empty and head.
- The parent keeps the FSM, the compare logic and the registered outputs.

Test Plan:
1. Reset, then push idx=3 pred=1 fallthru=0x104, then resolve taken=1 target=0x200 -> next cycle upd_en=1, upd_addr=3, upd_taken=1, mispredict=0; queue empty.
2. Push idx=7 pred=1 fallthru=0x20, then resolve taken=0 jump=0 -> mispredict=1, redirect_pc=0x20; the next cycle has push_ready=0 (FLUSH); the cycle after, push_ready=1.
3. Push 4 entries -> push_ready=0. Push and resolve together while full -> push refused, count=3 after the edge.
4. Fill 3 entries, resolve the first as a mispredict while pushing a 4th -> count=0 after the edge, 4th entry dropped, next resolve sets underflow.
5. res_valid with an empty queue -> upd_en stays 0, underflow=1 and held until arst pulses; arst asserted mid-queue clears count and all outputs without a clock edge.
6. With BRU_STATS_EN: 3 resolves, 1 of them mispredicted -> stat_branches=3, stat_mispredicts=1. Force 65536 resolves -> stat_branches stays at 16'hFFFF.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: pending-entry layout, FSM states, stats width.
// Optional statistics counters are built only when BRU_STATS_EN is defined.
package bru_pkg;

  localparam int BRU_IDX_W  = 5;
  localparam int BRU_PC_W   = 32;
  localparam int BRU_STAT_W = 16;

  typedef struct packed {
    logic [BRU_IDX_W-1:0] idx;
    logic                 pred;
    logic [BRU_PC_W-1:0]  fallthru;
  } bru_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bru_state_e;

  function automatic logic [BRU_STAT_W-1:0] bru_sat_inc(input logic [BRU_STAT_W-1:0] v);
    return (v == {BRU_STAT_W{1'b1}}) ? v : v + BRU_STAT_W'(1);
  endfunction

endpackage

// File: rtl/bru_fifo.sv
// In-order circular queue of pending branches; head is visible combinationally.
// Pushes while full and pops while empty are ignored; clear wins over push/pop.
module bru_fifo #(
  parameter int DATA_W = 38,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  input  logic              clr_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

  // Payload storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves predicted branches oldest-first, drives BHT updates and mispredict redirects.
// BRU_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int LOWER = BRU_IDX_W,
  parameter int DEPTH = 4,
  parameter int PC_W  = BRU_PC_W
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [LOWER-1:0] push_idx,
  input  logic             push_pred,
  input  logic [PC_W-1:0]  push_fallthru,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic             res_jump,
  input  logic [PC_W-1:0]  res_target,
  output logic             upd_en,
  output logic [LOWER-1:0] upd_addr,
  output logic             upd_taken,
  output logic             upd_jumped,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
`ifdef BRU_STATS_EN
  output logic [BRU_STAT_W-1:0] stat_branches,
  output logic [BRU_STAT_W-1:0] stat_mispredicts,
`endif
  output logic             underflow
);

  localparam int ENT_W = LOWER + 1 + PC_W;

  bru_state_e        state_q;
  logic              full, empty, in_run;
  logic [ENT_W-1:0]  head_dat;
  logic [LOWER-1:0]  head_idx;
  logic              head_pred;
  logic [PC_W-1:0]   head_ft;
  logic              resolve, actual, mis_d;
  logic [PC_W-1:0]   redirect_d;

  logic              upd_en_q, upd_taken_q, upd_jumped_q, mispredict_q, underflow_q;
  logic [LOWER-1:0]  upd_addr_q;
  logic [PC_W-1:0]   redirect_q;

  assign {head_idx, head_pred, head_ft} = head_dat;

  assign in_run     = (state_q == RUN);
  assign push_ready = !full && in_run;
  assign resolve    = res_valid && !empty && in_run;
  assign actual     = res_taken | res_jump;
  assign mis_d      = resolve && (actual != head_pred);
  assign redirect_d = actual ? res_target : head_ft;

  // A mispredict wipes the queue, so the head pop and any same-cycle push are moot.
  bru_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .arst    (arst),
    .push_i  (push_valid && push_ready && !mis_d),
    .data_i  ({push_idx, push_pred, push_fallthru}),
    .pop_i   (resolve && !mis_d),
    .clr_i   (mis_d),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head_dat)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= RUN;
      upd_en_q     <= 1'b0;
      upd_addr_q   <= '0;
      upd_taken_q  <= 1'b0;
      upd_jumped_q <= 1'b0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      underflow_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN:     if (mis_d) state_q <= FLUSH;
        FLUSH:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
      upd_en_q     <= resolve;
      mispredict_q <= mis_d;
      if (resolve) begin
        upd_addr_q   <= head_idx;
        upd_taken_q  <= res_taken;
        upd_jumped_q <= res_jump;
        redirect_q   <= redirect_d;
      end
      // Resolves are ignored during FLUSH, so they never count as underflow there.
      if (res_valid && empty && in_run) underflow_q <= 1'b1;
    end
  end

  assign upd_en      = upd_en_q;
  assign upd_addr    = upd_addr_q;
  assign upd_taken   = upd_taken_q;
  assign upd_jumped  = upd_jumped_q;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_q;
  assign underflow   = underflow_q;

`ifdef BRU_STATS_EN
  logic [BRU_STAT_W-1:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (resolve) stat_br_q <= bru_sat_inc(stat_br_q);
      if (mis_d)   stat_mp_q <= bru_sat_inc(stat_mp_q);
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized plus directed bench for branch_resolve_unit against a queue-based reference model.
// Define BRU_STATS_EN to also exercise the statistics counters.
module tb_branch_resolve_unit;

  localparam int LOWER = 5;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic             clk = 1'b0;
  logic             arst;
  logic             push_valid, push_ready, push_pred;
  logic [LOWER-1:0] push_idx;
  logic [PC_W-1:0]  push_fallthru;
  logic             res_valid, res_taken, res_jump;
  logic [PC_W-1:0]  res_target;
  logic             upd_en, upd_taken, upd_jumped, mispredict, underflow;
  logic [LOWER-1:0] upd_addr;
  logic [PC_W-1:0]  redirect_pc;
`ifdef BRU_STATS_EN
  logic [15:0]      stat_branches, stat_mispredicts;
`endif

  branch_resolve_unit #(.LOWER(LOWER), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk           (clk),
    .arst          (arst),
    .push_valid    (push_valid),
    .push_ready    (push_ready),
    .push_idx      (push_idx),
    .push_pred     (push_pred),
    .push_fallthru (push_fallthru),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .res_jump      (res_jump),
    .res_target    (res_target),
    .upd_en        (upd_en),
    .upd_addr      (upd_addr),
    .upd_taken     (upd_taken),
    .upd_jumped    (upd_jumped),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc),
`ifdef BRU_STATS_EN
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts),
`endif
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending branches as a plain queue, plus the expected output registers.
  typedef struct {
    logic [LOWER-1:0] idx;
    logic             pred;
    logic [PC_W-1:0]  ft;
  } ent_t;

  ent_t             q[$];
  bit               m_flush;
  logic             m_upd_en, m_taken, m_jumped, m_mis, m_uf;
  logic [LOWER-1:0] m_addr;
  logic [PC_W-1:0]  m_redir;
  int               m_br, m_mp;

  function automatic void model_reset();
    q.delete();
    m_flush = 0; m_upd_en = 0; m_taken = 0; m_jumped = 0; m_mis = 0; m_uf = 0;
    m_addr = '0; m_redir = '0; m_br = 0; m_mp = 0;
  endfunction

  function automatic bit model_ready();
    return (q.size() < DEPTH) && !m_flush;
  endfunction

  function automatic void model_step(input logic pv, input ent_t e, input logic rv,
                                     input logic tk, input logic jp, input logic [PC_W-1:0] tgt);
    bit ready, act;
    ready = model_ready();
    m_upd_en = 0;
    m_mis = 0;
    if (m_flush) begin
      m_flush = 0;
      return;
    end
    if (rv && q.size() == 0) m_uf = 1;
    if (rv && q.size() > 0) begin
      act      = tk || jp;
      m_upd_en = 1;
      m_addr   = q[0].idx;
      m_taken  = tk;
      m_jumped = jp;
      m_redir  = act ? tgt : q[0].ft;
      m_mis    = (act != q[0].pred);
      if (m_br < 65535) m_br++;
      if (m_mis && m_mp < 65535) m_mp++;
    end
    if (m_mis) begin
      q.delete();
      m_flush = 1;
    end else begin
      if (m_upd_en) void'(q.pop_front());
      if (pv && ready) q.push_back(e);
    end
  endfunction

  task automatic compare_all();
    check("upd_en", 64'(upd_en), 64'(m_upd_en));
    check("mispredict", 64'(mispredict), 64'(m_mis));
    check("underflow", 64'(underflow), 64'(m_uf));
    check("push_ready", 64'(push_ready), 64'(model_ready()));
    check("upd_addr", 64'(upd_addr), 64'(m_addr));
    check("upd_taken", 64'(upd_taken), 64'(m_taken));
    check("upd_jumped", 64'(upd_jumped), 64'(m_jumped));
    check("redirect_pc", 64'(redirect_pc), 64'(m_redir));
`ifdef BRU_STATS_EN
    check("stat_branches", 64'(stat_branches), 64'(m_br));
    check("stat_mispredicts", 64'(stat_mispredicts), 64'(m_mp));
`endif
  endtask

  // Drive one cycle of inputs (from a point after the falling edge), clock it, compare at the next falling edge.
  task automatic cycle(input logic pv, input logic [LOWER-1:0] idx, input logic pred,
                       input logic [PC_W-1:0] ft, input logic rv, input logic tk,
                       input logic jp, input logic [PC_W-1:0] tgt);
    ent_t e;
    push_valid = pv; push_idx = idx; push_pred = pred; push_fallthru = ft;
    res_valid = rv; res_taken = tk; res_jump = jp; res_target = tgt;
    e.idx = idx; e.pred = pred; e.ft = ft;
    model_step(pv, e, rv, tk, jp, tgt);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    cycle(0, '0, 0, '0, 0, 0, 0, '0);
  endtask

  task automatic do_reset();
    arst = 1'b1;
    push_valid = 0; push_idx = '0; push_pred = 0; push_fallthru = '0;
    res_valid = 0; res_taken = 0; res_jump = 0; res_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    model_reset();
    compare_all();
  endtask

  initial begin
    do_reset();

    // Correctly predicted taken branch.
    cycle(1, 5'd3, 1, 32'h104, 0, 0, 0, '0);
    cycle(0, '0, 0, '0, 1, 1, 0, 32'h200);
    check("t1_upd_en", 64'(upd_en), 64'd1);
    check("t1_upd_addr", 64'(upd_addr), 64'd3);
    check("t1_mispredict", 64'(mispredict), 64'd0);

    // Predicted taken, actually not taken: redirect to fall-through, one FLUSH cycle.
    cycle(1, 5'd7, 1, 32'h20, 0, 0, 0, '0);
    cycle(0, '0, 0, '0, 1, 0, 0, 32'h999);
    check("t2_mispredict", 64'(mispredict), 64'd1);
    check("t2_redirect", 64'(redirect_pc), 64'h20);
    check("t2_ready_flush", 64'(push_ready), 64'd0);
    idle();
    check("t2_ready_run", 64'(push_ready), 64'd1);

    // Fill, then push+resolve while full: push refused, three entries remain.
    for (int i = 0; i < 4; i++) cycle(1, 5'(i + 10), 1, 32'(i * 4), 0, 0, 0, '0);
    check("t3_full_ready", 64'(push_ready), 64'd0);
    cycle(1, 5'd31, 0, 32'hBAD, 1, 1, 0, 32'h300);
    check("t3_ready_after", 64'(push_ready), 64'd1);
    for (int i = 0; i < 3; i++) cycle(0, '0, 0, '0, 1, 1, 0, 32'h400);
    check("t3_last_addr", 64'(upd_addr), 64'd13);
    check("t3_no_underflow", 64'(underflow), 64'd0);

    // Mispredict with a concurrent push: all entries and the push are dropped.
    for (int i = 0; i < 3; i++) cycle(1, 5'(i + 20), 1, 32'(i * 8), 0, 0, 0, '0);
    cycle(1, 5'd23, 1, 32'h77, 1, 0, 0, '0);
    check("t4_mispredict", 64'(mispredict), 64'd1);
    idle();
    cycle(0, '0, 0, '0, 1, 1, 0, '0);
    check("t4_upd_en", 64'(upd_en), 64'd0);
    check("t4_underflow", 64'(underflow), 64'd1);

    // Sticky underflow, then asynchronous reset between clock edges.
    cycle(0, '0, 0, '0, 1, 0, 1, '0);
    for (int i = 0; i < 2; i++) cycle(1, 5'(i), 0, 32'h50, 0, 0, 0, '0);
    check("t5_underflow_held", 64'(underflow), 64'd1);
    cycle(1, 5'd9, 1, 32'h60, 1, 0, 1, 32'h1234);
    #2 arst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("t5_arst_underflow", 64'(underflow), 64'd0);
    #1 arst = 1'b0;
    idle();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom),
            $urandom, ($urandom_range(0, 2) == 0), 1'($urandom),
            ($urandom_range(0, 7) == 0), $urandom);
    end

`ifdef BRU_STATS_EN
    do_reset();
    cycle(1, 5'd1, 1, 32'h10, 0, 0, 0, '0);
    cycle(1, 5'd2, 0, 32'h20, 1, 1, 0, 32'h80);
    cycle(1, 5'd3, 1, 32'h30, 1, 0, 0, '0);
    cycle(0, '0, 0, '0, 1, 0, 0, '0);
    check("t6_branches", 64'(stat_branches), 64'd3);
    check("t6_mispredicts", 64'(stat_mispredicts), 64'd1);
    idle();
    cycle(1, 5'd4, 1, 32'h40, 0, 0, 0, '0);
    for (int i = 0; i < 65540; i++) cycle(1, 5'd4, 1, 32'h40, 1, 1, 0, 32'h44);
    check("t6_saturated", 64'(stat_branches), 64'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
